// File: rtl/port_arb.sv
// Round-robin write-side arbiter for one output port of the multi-port cache.
// Grants one requesting channel at a time and forwards its packet to the RAM writer.
module port_arb #(
    parameter int unsigned PORTNUM = 16,
    parameter int unsigned DWIDTH  = 32,
    parameter logic [3:0]  PORT_ID = 4'd0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [PORTNUM-1:0]                   i_req,
    input  logic [PORTNUM*DWIDTH-1:0]            i_data,
    input  logic [PORTNUM-1:0]                   i_data_vld,
    input  logic [PORTNUM-1:0]                   i_eop,
    input  logic                                 i_ready,
    output logic [PORTNUM-1:0]                   o_resp,
    output logic [PORTNUM-1:0]                   o_nresp,
    output logic [DWIDTH-1:0]                    o_data,
    output logic                                 o_data_vld,
    output logic                                 o_eop,
    output logic [$clog2(PORTNUM)-1:0]           o_grant_id,
    output logic                                 o_busy
);

    localparam int unsigned    IDW     = $clog2(PORTNUM);
    localparam int unsigned    TW      = $clog2(TIMEOUT + 1);
    localparam logic [IDW-1:0] PTR_RST = IDW'(PORTNUM - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_grant_id;
    logic [TW-1:0]        r_timer;
    logic [PORTNUM-1:0]   r_resp;
    logic [PORTNUM-1:0]   r_nresp;
    logic [DWIDTH-1:0]    r_data;
    logic                 r_data_vld;
    logic                 r_eop;

    logic [DWIDTH-1:0]    w_data_arr [PORTNUM];
    logic [IDW-1:0]       w_cand;
    logic [IDW-1:0]       w_arb_idx;
    logic                 w_arb_found;
    logic [PORTNUM-1:0]   w_resp_next;
    logic                 w_grant;
    logic                 w_done;
    logic                 w_win_vld;
    logic                 w_win_eop;
    logic                 w_win_req;

    always_comb begin
        for (int unsigned k = 0; k < PORTNUM; k++) begin
            w_data_arr[k] = i_data[k*DWIDTH +: DWIDTH];
        end
    end

    // Scan upward from ptr+1 with wrap; the last grantee ends up lowest priority.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_cand      = '0;
        for (int unsigned i = 1; i <= PORTNUM; i++) begin
            w_cand = IDW'((32'(r_ptr) + i) % PORTNUM);
            if (!w_arb_found && i_req[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    assign w_win_vld = i_data_vld[r_grant_id];
    assign w_win_eop = i_eop[r_grant_id];
    assign w_win_req = i_req[r_grant_id];

    always_comb begin
        w_state_next = r_state;
        w_resp_next  = r_resp;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_resp_next = '0;
                if (i_ready && w_arb_found) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_BUSY;
                    w_resp_next  = PORTNUM'(1) << w_arb_idx;
                end
            end
            ST_BUSY: begin
                // A valid eop completes normally even if an abort condition coincides.
                if (w_win_vld && w_win_eop) begin
                    w_done = 1'b1;
                end else if (!w_win_req || (!w_win_vld && r_timer == T_LAST)) begin
                    w_done = 1'b1;
                end
                if (w_done) begin
                    w_state_next = ST_IDLE;
                    w_resp_next  = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_resp_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PTR_RST;
            r_grant_id <= '0;
            r_timer    <= '0;
            r_resp     <= '0;
            r_nresp    <= '0;
            r_data     <= '0;
            r_data_vld <= 1'b0;
            r_eop      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_resp     <= w_resp_next;
            r_nresp    <= i_req & ~w_resp_next;
            r_data_vld <= 1'b0;
            r_eop      <= 1'b0;
            if (w_grant) begin
                r_grant_id <= w_arb_idx;
                r_timer    <= '0;
            end
            if (r_state == ST_BUSY) begin
                r_data_vld <= w_win_vld;
                r_eop      <= w_win_vld && w_win_eop;
                if (w_win_vld) begin
                    r_data  <= w_data_arr[r_grant_id];
                    r_timer <= '0;
                end else if (r_timer != '1) begin
                    r_timer <= r_timer + 1'b1;
                end
                if (w_done) begin
                    r_ptr <= r_grant_id;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert ($onehot0(r_resp) && ((r_resp & r_nresp) == '0))
                else $error("port_arb %0d: resp not one-hot or overlaps nresp", PORT_ID);
        end
    end

    assign o_resp     = r_resp;
    assign o_nresp    = r_nresp;
    assign o_data     = r_data;
    assign o_data_vld = r_data_vld;
    assign o_eop      = r_eop;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state == ST_BUSY);

endmodule

// File: tb/tb_port_arb.sv
// Self-checking bench for port_arb: directed vector table, corner-case sequences,
// and randomized traffic checked cycle by cycle against a behavioural model.
module tb_port_arb;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic [N-1:0]      req;
    logic [N-1:0]      vld;
    logic [N-1:0]      eop;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      resp;
    logic [N-1:0]      nresp;
    logic [DW-1:0]     odata;
    logic              ovld;
    logic              oeop;
    logic [3:0]        gid;
    logic              busy;

    always #5 clk = ~clk;

    port_arb #(
        .PORTNUM(N),
        .DWIDTH (DW),
        .PORT_ID(4'd3),
        .TIMEOUT(TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_data    (data),
        .i_data_vld(vld),
        .i_eop     (eop),
        .i_ready   (ready),
        .o_resp    (resp),
        .o_nresp   (nresp),
        .o_data    (odata),
        .o_data_vld(ovld),
        .o_eop     (oeop),
        .o_grant_id(gid),
        .o_busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: owner index, priority pointer and idle count as plain ints.
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_idle;
    logic [15:0] e_resp;
    logic [15:0] e_nresp;
    logic [31:0] e_data;
    bit          e_vld;
    bit          e_eop;
    int          e_gid;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int d = 1; d <= N; d++) begin
            if (r[(p + d) % N]) return (p + d) % N;
        end
        return -1;
    endfunction

    function automatic void model_step();
        int  o;
        bit  v;
        bit  fin;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = N - 1; m_idle = 0;
            e_resp = '0; e_nresp = '0; e_data = '0; e_vld = 0; e_eop = 0; e_gid = 0;
            return;
        end
        e_vld = 0;
        e_eop = 0;
        if (!m_busy) begin
            if (ready && req != '0) begin
                m_owner = pick(req, m_ptr);
                m_busy  = 1;
                m_idle  = 0;
                e_gid   = m_owner;
            end
        end else begin
            o = m_owner;
            v = vld[o];
            if (v) begin
                e_vld  = 1;
                e_eop  = eop[o];
                e_data = data[o*DW +: DW];
            end
            fin = (v && eop[o]) || !req[o] || (!v && m_idle == TO - 1);
            m_idle = v ? 0 : m_idle + 1;
            if (fin) begin
                m_busy = 0;
                m_ptr  = o;
            end
        end
        e_resp  = m_busy ? 16'(1 << m_owner) : 16'h0;
        e_nresp = req & ~e_resp;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("resp",  32'(resp),  32'(e_resp));
        check("nresp", 32'(nresp), 32'(e_nresp));
        check("vld",   32'(ovld),  32'(e_vld));
        check("eop",   32'(oeop),  32'(e_eop));
        check("busy",  32'(busy),  32'(m_busy));
        check("gid",   32'(gid),   32'(e_gid));
        if (e_vld) check("data", odata, e_data);
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b1; req = '0; vld = '0; eop = '0;
        step();
        rst = 1'b0;
    endtask

    int wc = 0;
    // Granted channel sends len words back to back, eop on the last.
    task automatic agent(input int len);
        vld = '0;
        eop = '0;
        if (resp == '0) begin
            wc = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (resp[k]) begin
                    vld[k] = 1'b1;
                    eop[k] = (wc == len - 1);
                end
            end
            wc++;
        end
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        logic [15:0] req;
        logic [15:0] vld;
        logic [15:0] eop;
        logic [15:0] x_resp;
        logic [15:0] x_nresp;
        bit          x_vld;
        bit          x_eop;
        logic [31:0] x_data;
        bit          x_busy;
        int          x_gid;
    } vec_t;

    vec_t vt [11];
    int   order [$];
    int   exp_order [5];
    int   bc;
    bit   prevb;
    bit   saw_eop;

    initial begin
        rst = 1'b1; ready = 1'b0; req = '0; vld = '0; eop = '0; data = '0;

        // channel k word in row r is D000_0000 + k*256 + r
        vt[0]  = '{1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 32'h0,         0, 0};
        vt[1]  = '{0, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 32'h0,         1, 0};
        vt[2]  = '{0, 1, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1, 0, 32'hD000_0002, 1, 0};
        vt[3]  = '{0, 1, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1, 0, 32'hD000_0003, 1, 0};
        vt[4]  = '{0, 1, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1, 0, 32'hD000_0004, 1, 0};
        vt[5]  = '{0, 1, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1, 1, 32'hD000_0005, 0, 0};
        vt[6]  = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 32'h0,         0, 0};
        vt[7]  = '{0, 0, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 0, 0, 32'h0,         0, 0};
        vt[8]  = '{0, 1, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0, 0, 32'h0,         1, 1};
        vt[9]  = '{0, 1, 16'h0002, 16'h0002, 16'h0002, 16'h0000, 16'h0002, 1, 1, 32'hD000_0109, 0, 1};
        vt[10] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 32'h0,         0, 1};

        for (int r = 0; r < 11; r++) begin
            rst = vt[r].rst; ready = vt[r].ready; req = vt[r].req;
            vld = vt[r].vld; eop = vt[r].eop;
            for (int k = 0; k < N; k++) data[k*DW +: DW] = 32'hD000_0000 + 32'(k * 256 + r);
            step();
            check("tbl_resp",  32'(resp),  32'(vt[r].x_resp));
            check("tbl_nresp", 32'(nresp), 32'(vt[r].x_nresp));
            check("tbl_vld",   32'(ovld),  32'(vt[r].x_vld));
            check("tbl_eop",   32'(oeop),  32'(vt[r].x_eop));
            check("tbl_busy",  32'(busy),  32'(vt[r].x_busy));
            check("tbl_gid",   32'(gid),   32'(vt[r].x_gid));
            if (vt[r].x_vld) check("tbl_data", odata, vt[r].x_data);
        end

        // Round robin across channels 0, 1, 15 with 2-word packets
        do_reset();
        req = 16'h8003; wc = 0; prevb = 0;
        exp_order = '{0, 1, 15, 0, 1};
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            agent(2);
            step();
            if (busy && !prevb) order.push_back(int'(gid));
            prevb = busy;
        end
        check("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
        for (int c = 0; c < 20 && busy; c++) begin agent(2); step(); end
        req = '0; vld = '0; eop = '0;
        step();

        // Not ready: requester only sees nresp, granted once ready rises
        do_reset();
        ready = 1'b0; req = 16'h0010;
        repeat (10) step();
        check("nr_resp",  32'(resp),  32'h0);
        check("nr_nresp", 32'(nresp), 32'h0010);
        ready = 1'b1;
        step();
        check("nr_grant", 32'(resp), 32'h0010);
        check("nr_gid",   32'(gid),  32'd4);
        vld = 16'h0010; eop = 16'h0010;
        step();
        check("nr_eop", 32'(oeop), 32'd1);
        req = '0; vld = '0; eop = '0;
        step(); step();

        // Timeout abort on ch2, then ch3 wins
        do_reset();
        req = 16'h000C;
        step();
        check("to_gid", 32'(gid), 32'd2);
        bc = busy ? 1 : 0; saw_eop = 0;
        for (int c = 0; c < 200 && busy; c++) begin
            step();
            if (busy) bc++;
            if (oeop) saw_eop = 1;
        end
        check("to_len", 32'(bc), 32'(TO));
        check("to_noeop", 32'(saw_eop), 32'd0);
        step();
        check("to_next", 32'(resp), 32'h0008);
        check("to_next_gid", 32'(gid), 32'd3);
        req = '0;
        step(); step();

        // Reset mid-packet on ch5, then ch0 has priority
        do_reset();
        req = 16'h0020;
        step();
        vld = 16'h0020; data[5*DW +: DW] = 32'h5555_0001;
        step(); step();
        rst = 1'b1;
        step();
        check("rs_resp", 32'(resp), 32'h0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_eop",  32'(oeop), 32'd0);
        rst = 1'b0; vld = '0; req = 16'h0021;
        step();
        check("rs_prio", 32'(resp), 32'h0001);
        req = '0;
        step(); step();

        // ch7 drops request mid-packet; ch6 valid data is ignored until granted
        do_reset();
        req = 16'h0080;
        step();
        req = 16'h00C0; vld = 16'h00C0; eop = '0;
        data[7*DW +: DW] = 32'h7777_0001;
        data[6*DW +: DW] = 32'h6666_6666;
        step();
        check("ab_data", odata, 32'h7777_0001);
        req = 16'h0040; vld = 16'h0040;
        step();
        check("ab_vld",  32'(ovld), 32'd0);
        check("ab_eop",  32'(oeop), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        step();
        check("ab_next", 32'(gid), 32'd6);
        eop = 16'h0040;
        step();
        check("ab_d6",   odata, 32'h6666_6666);
        check("ab_e6",   32'(oeop), 32'd1);
        req = '0; vld = '0; eop = '0;
        step(); step();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) req ^= 16'(1 << $urandom_range(0, N - 1));
            ready = ($urandom_range(0, 3) != 0);
            if (c < 2000) vld = 16'($urandom);
            else          vld = 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom);
            eop = 16'($urandom) & 16'($urandom);
            for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
